// File: rtl/dram_arbiter.sv
// Two-master arbiter for a single-port DRAM: CPU (m0) and loader/debug (m1),
// round-robin with a bounded burst lock for m1, one-cycle read return routing.
module dram_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_wdin,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rd,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic        m1_lock,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_wdin,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rd,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdin,
   output logic        mem_we,
   input  logic [31:0] mem_rd,
   output logic [15:0] cpu_stall_cnt
);

   typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_t;

   localparam logic [3:0] MAX_HOLD_W = 4'(MAX_HOLD);

   owner_t      last_gnt, last_gnt_nxt;
   owner_t      tag, tag_nxt, owner;
   logic [3:0]  hold_cnt, hold_nxt;
   logic        pending, pending_nxt;
   logic [15:0] stall_q, stall_nxt;
   logic        gnt0, gnt1;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= OWN_M1;
         hold_cnt <= '0;
         pending  <= 1'b0;
         tag      <= OWN_M0;
         stall_q  <= '0;
      end else begin
         last_gnt <= last_gnt_nxt;
         hold_cnt <= hold_nxt;
         pending  <= pending_nxt;
         tag      <= tag_nxt;
         stall_q  <= stall_nxt;
      end
   end

   // Grant decision; the lock only matters when both masters contend
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (m0_req && m1_req) begin
            if (last_gnt == OWN_M1 && m1_lock && hold_cnt < MAX_HOLD_W)
               gnt1 = 1'b1;
            else if (last_gnt == OWN_M1)
               gnt0 = 1'b1;
            else
               gnt1 = 1'b1;
         end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
         end
      end
   end

   // Next-state logic
   always_comb begin
      last_gnt_nxt = last_gnt;
      hold_nxt     = hold_cnt;
      owner        = gnt1 ? OWN_M1 : OWN_M0;
      pending_nxt  = (gnt0 && !m0_we) || (gnt1 && !m1_we);
      tag_nxt      = pending_nxt ? owner : tag;
      stall_nxt    = stall_q;
      if (gnt0 || gnt1) begin
         if (owner == last_gnt) begin
            if (hold_cnt != 4'hF)
               hold_nxt = hold_cnt + 4'd1;
         end else begin
            last_gnt_nxt = owner;
            hold_nxt     = 4'd1;
         end
      end
      if (m0_req && !gnt0 && stall_q != '1)
         stall_nxt = stall_q + 16'd1;
   end

   // Outputs; read return is gated by rst so a read straddling reset is dropped
   always_comb begin
      m0_gnt    = gnt0;
      m1_gnt    = gnt1;
      mem_adr   = '0;
      mem_wdin  = '0;
      mem_we    = 1'b0;
      if (gnt0) begin
         mem_adr  = m0_adr;
         mem_wdin = m0_wdin;
         mem_we   = m0_we;
      end else if (gnt1) begin
         mem_adr  = m1_adr;
         mem_wdin = m1_wdin;
         mem_we   = m1_we;
      end
      m0_rvalid     = pending && tag == OWN_M0 && !rst;
      m1_rvalid     = pending && tag == OWN_M1 && !rst;
      m0_rd         = m0_rvalid ? mem_rd : '0;
      m1_rd         = m1_rvalid ? mem_rd : '0;
      cpu_stall_cnt = stall_q;
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: driver pushes expected per-cycle grant and
// read-return records, a negedge monitor pops and compares them.
module tb_dram_arbiter;

   localparam logic [31:0] KEY = 32'hDEADBFEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_adr = '0, m0_wdin = '0;
   logic        m0_gnt, m0_rvalid;
   logic [31:0] m0_rd;
   logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
   logic [31:0] m1_adr = '0, m1_wdin = '0;
   logic        m1_gnt, m1_rvalid;
   logic [31:0] m1_rd;
   logic [31:0] mem_adr, mem_wdin;
   logic        mem_we;
   logic [31:0] mem_rd;
   logic [15:0] cpu_stall_cnt;
   logic [31:0] last_adr = '0;

   always #5 clk = ~clk;

   // DRAM model: data is a fixed function of the address presented last cycle
   always @(posedge clk) last_adr <= mem_adr;
   assign mem_rd = last_adr ^ KEY;

   dram_arbiter #(.MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdin(m0_wdin),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_adr(m1_adr),
      .m1_wdin(m1_wdin), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
      .mem_adr(mem_adr), .mem_wdin(mem_wdin), .mem_we(mem_we), .mem_rd(mem_rd),
      .cpu_stall_cnt(cpu_stall_cnt)
   );

   typedef struct {
      bit          g0, g1, we;
      logic [31:0] adr, wdin;
      bit          chk;
      logic [15:0] stall;
   } exp_t;

   typedef struct {
      bit          own;
      int unsigned due;
      logic [31:0] data;
   } rd_t;

   exp_t        exp_q[$];
   rd_t         rd_q[$];
   int unsigned cur_cyc = 0;
   int unsigned tests = 0;
   int unsigned failed = 0;
   logic [15:0] stall_model = '0;
   bit          stall_ok = 1'b0;
   bit          last_rd = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s cyc %0d: got %h expected %h", name, cur_cyc, act, req);
      end
   endtask

   task automatic cyc(input bit r,
                      input bit a_req, input bit a_we, input logic [31:0] a_adr, input logic [31:0] a_wd,
                      input bit b_req, input bit b_we, input bit b_lock, input logic [31:0] b_adr,
                      input logic [31:0] b_wd, input bit eg0, input bit eg1);
      exp_t e;
      rd_t  rr;
      @(posedge clk);
      #1;
      rst = r;
      m0_req = a_req; m0_we = a_we; m0_adr = a_adr; m0_wdin = a_wd;
      m1_req = b_req; m1_we = b_we; m1_lock = b_lock; m1_adr = b_adr; m1_wdin = b_wd;
      cur_cyc++;
      if (r && last_rd) void'(rd_q.pop_back());
      e.g0 = eg0; e.g1 = eg1;
      e.we   = eg0 ? a_we : (eg1 ? b_we : 1'b0);
      e.adr  = eg0 ? a_adr : (eg1 ? b_adr : 32'h0);
      e.wdin = eg0 ? a_wd : (eg1 ? b_wd : 32'h0);
      e.chk = stall_ok; e.stall = stall_model;
      exp_q.push_back(e);
      last_rd = 1'b0;
      if ((eg0 && !a_we) || (eg1 && !b_we)) begin
         rr.own = eg1; rr.due = cur_cyc + 1; rr.data = (eg0 ? a_adr : b_adr) ^ KEY;
         rd_q.push_back(rr);
         last_rd = 1'b1;
      end
      if (r) begin
         stall_model = '0; stall_ok = 1'b1;
      end else if (a_req && !eg0 && stall_model != 16'hFFFF)
         stall_model = stall_model + 16'd1;
   endtask

   task automatic idle(input bit r);
      cyc(r, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      rd_t  rr;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("m0_gnt", 32'(m0_gnt), 32'(e.g0));
         chk("m1_gnt", 32'(m1_gnt), 32'(e.g1));
         chk("mem_we", 32'(mem_we), 32'(e.we));
         chk("mem_adr", mem_adr, e.adr);
         chk("mem_wdin", mem_wdin, e.wdin);
         if (e.chk) chk("stall_cnt", 32'(cpu_stall_cnt), 32'(e.stall));
      end
      if (cur_cyc > 0) begin
         if (rd_q.size() != 0 && rd_q[0].due == cur_cyc) begin
            rr = rd_q.pop_front();
            chk("m0_rvalid", 32'(m0_rvalid), 32'(!rr.own));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(rr.own));
            chk(rr.own ? "m1_rd" : "m0_rd", rr.own ? m1_rd : m0_rd, rr.data);
         end else begin
            chk("m0_rvalid_idle", 32'(m0_rvalid), 32'h0);
            chk("m1_rvalid_idle", 32'(m1_rvalid), 32'h0);
         end
         if (!m0_rvalid) chk("m0_rd_zero", m0_rd, 32'h0);
         if (!m1_rvalid) chk("m1_rd_zero", m1_rd, 32'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with both requesting
      cyc(1, 1, 1, 32'h55, 32'h66, 1, 0, 0, 32'h77, 32'h0, 0, 0);
      cyc(1, 1, 1, 32'h55, 32'h66, 1, 0, 0, 32'h77, 32'h0, 0, 0);
      // Solo read, stall counter must read 0 in the first cycle after release
      cyc(0, 1, 0, 32'h100, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
      idle(0);
      idle(0);
      // Round robin, back-to-back alternating reads
      idle(1);
      for (int i = 0; i < 4; i++)
         cyc(0, 1, 0, 32'h200 + 32'(i), 32'h0, 1, 0, 0, 32'h300 + 32'(i), 32'h0, (i % 2) == 0, (i % 2) == 1);
      idle(0);
      // Burst lock: 1111 0 1111 0, writes only
      idle(1);
      for (int i = 0; i < 10; i++)
         cyc(0, 1, 1, 32'h400, 32'hA0 + 32'(i), 1, 1, 1, 32'h500, 32'hB0 + 32'(i), (i % 5) == 4, (i % 5) != 4);
      idle(0);
      // Write vs read conflict with last_gnt=1, no lock
      idle(1);
      cyc(0, 1, 1, 32'h40, 32'h12345678, 1, 0, 0, 32'h80, 32'h0, 1, 0);
      cyc(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h80, 32'h0, 0, 1);
      idle(0);
      // Idle m0 fields and m1 lock ignored with a sole requester
      cyc(0, 0, 1, 32'hFFFF, 32'hFFFF, 1, 1, 1, 32'h44, 32'h99, 0, 1);
      cyc(0, 1, 0, 32'h60, 32'h0, 0, 1, 1, 32'h33, 32'h0, 1, 0);
      // Read accepted right before reset is dropped
      cyc(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h500, 32'h0, 0, 1);
      cyc(1, 1, 0, 32'h1, 32'h0, 1, 0, 0, 32'h2, 32'h0, 0, 0);
      idle(0);
      // Saturation: preload near the top, then keep m0 stalled behind the lock
      @(negedge clk);
      #1;
      force dut.stall_q = 16'hFFFE;
      #1;
      release dut.stall_q;
      stall_model = 16'hFFFE;
      for (int i = 0; i < 3; i++)
         cyc(0, 1, 1, 32'h10, 32'h0, 1, 1, 1, 32'h20, 32'h0, 0, 1);
      idle(0);
      idle(0);
      @(negedge clk);
      @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
      chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
